// File: rtl/mdio_pkg.sv
// rtl/mdio_pkg.sv - shared opcodes, FSM states and BMSR bit position for the MDIO arbiter
package mdio_pkg;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam int         BMSR_LINK_BIT = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RESP
  } state_t;

  function automatic logic op_legal(input logic [1:0] op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction

endpackage

// File: rtl/mdio_rr_arbiter.sv
// rtl/mdio_rr_arbiter.sv - combinational round-robin picker; search starts one past the last winner
module mdio_rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int off = 1; off <= N; off++) begin
      for (int j = 0; j < N; j++) begin
        if (!any && req[j] && (j == (int'(last) + off) % N)) begin
          any      = 1'b1;
          grant[j] = 1'b1;
          idx      = IW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/mdio_arbiter.sv
// rtl/mdio_arbiter.sv - round-robin sharing of one mdio_ctrl engine between NREQ requesters
// Optional link poller enabled by MDIO_POLL_EN.
module mdio_arbiter
  import mdio_pkg::*;
#(
  parameter int         NREQ        = 2,
  parameter logic [4:0] POLL_PHY    = 5'd0,
  parameter logic [4:0] POLL_REG    = 5'd1,
  parameter int         POLL_PERIOD = 1000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [5*NREQ-1:0]    req_phy_addr,
  input  logic [5*NREQ-1:0]    req_reg_addr,
  input  logic [16*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [15:0]          rsp_rdata,
  output logic                 rsp_error,
  output logic [4:0]           mdio_phy_addr,
  output logic [4:0]           mdio_reg_addr,
  output logic [15:0]          mdio_wdata,
  output logic [1:0]           mdio_op,
  output logic                 mdio_start,
  input  logic                 mdio_ready,
  input  logic [15:0]          mdio_rdata,
  input  logic                 mdio_error,
  output logic                 link_up,
  output logic                 link_change
);

  localparam int NC = NREQ + 1;
  localparam int IW = $clog2(NC);

  if (NREQ < 1 || NREQ > 8 || POLL_PERIOD < 2) begin : g_bad_cfg
    $error("mdio_arbiter: unsupported NREQ or POLL_PERIOD");
  end

  state_t        state, state_nxt;
  logic [IW-1:0] gnt_idx, last_ptr, arb_idx;
  logic [NC-1:0] cand, arb_grant;
  logic          arb_any, take, illegal_q, poll_pend;
  logic [1:0]    sel_op;
  logic [4:0]    sel_phy, sel_reg;
  logic [15:0]   sel_wdata, rdata_q;
  logic          error_q;

  // The poller occupies the highest candidate slot.
  assign cand = {poll_pend, req_valid};

  mdio_rr_arbiter #(.N(NC), .IW(IW)) u_rr (
    .req   (cand),
    .last  (last_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  always_comb begin
    sel_op    = '0;
    sel_phy   = '0;
    sel_reg   = '0;
    sel_wdata = '0;
    if (arb_grant[NREQ]) begin
      sel_op  = OP_READ;
      sel_phy = POLL_PHY;
      sel_reg = POLL_REG;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (arb_grant[i]) begin
        sel_op    = req_op[2*i +: 2];
        sel_phy   = req_phy_addr[5*i +: 5];
        sel_reg   = req_reg_addr[5*i +: 5];
        sel_wdata = req_wdata[16*i +: 16];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      S_IDLE: begin
        if (mdio_ready && arb_any) begin
          take      = 1'b1;
          // Illegal ops skip the frame and fall straight through to the response.
          state_nxt = op_legal(sel_op) ? S_ISSUE : S_WAIT_DONE;
        end
      end
      S_ISSUE:     state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: if (!mdio_ready) state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (illegal_q || mdio_ready) state_nxt = S_RESP;
      S_RESP:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  assign mdio_start = (state == S_ISSUE);
  assign rsp_rdata  = rdata_q;
  assign rsp_error  = error_q;

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid[i] = (state == S_RESP) && (gnt_idx == IW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      gnt_idx       <= '0;
      last_ptr      <= '0;
      req_ready     <= '0;
      illegal_q     <= 1'b0;
      mdio_op       <= '0;
      mdio_phy_addr <= '0;
      mdio_reg_addr <= '0;
      mdio_wdata    <= '0;
      rdata_q       <= '0;
      error_q       <= 1'b0;
    end else begin
      state     <= state_nxt;
      req_ready <= '0;
      if (take) begin
        gnt_idx       <= arb_idx;
        req_ready     <= arb_grant[NREQ-1:0];
        illegal_q     <= !op_legal(sel_op);
        mdio_op       <= sel_op;
        mdio_phy_addr <= sel_phy;
        mdio_reg_addr <= sel_reg;
        mdio_wdata    <= sel_wdata;
      end
      if (state == S_WAIT_DONE && state_nxt == S_RESP) begin
        rdata_q <= illegal_q ? 16'h0000 : mdio_rdata;
        error_q <= illegal_q | ((mdio_op != OP_WRITE) & mdio_error);
      end
      if (state == S_RESP) last_ptr <= gnt_idx;
    end
  end

`ifdef MDIO_POLL_EN
  logic [31:0] poll_timer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      poll_timer  <= '0;
      poll_pend   <= 1'b0;
      link_up     <= 1'b0;
      link_change <= 1'b0;
    end else begin
      link_change <= 1'b0;
      if (poll_timer == 32'(POLL_PERIOD - 1)) begin
        poll_timer <= '0;
        poll_pend  <= 1'b1;
      end else begin
        poll_timer <= poll_timer + 32'd1;
      end
      if (take && arb_grant[NREQ]) poll_pend <= 1'b0;
      if (state == S_RESP && gnt_idx == IW'(NREQ) && !error_q) begin
        link_up     <= rdata_q[BMSR_LINK_BIT];
        link_change <= (link_up != rdata_q[BMSR_LINK_BIT]);
      end
    end
  end
`else
  assign poll_pend   = 1'b0;
  assign link_up     = 1'b0;
  assign link_change = 1'b0;
`endif

endmodule

// File: tb/tb_mdio_arbiter.sv
// tb/tb_mdio_arbiter.sv - directed self-checking bench for mdio_arbiter with a behavioural mdio_ctrl
module tb_mdio_arbiter;

  localparam int NREQ  = 2;
  localparam int FRAME = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [2*NREQ-1:0] req_op = '0;
  logic [5*NREQ-1:0] req_phy_addr = '0;
  logic [5*NREQ-1:0] req_reg_addr = '0;
  logic [16*NREQ-1:0] req_wdata = '0;
  logic [NREQ-1:0]   rsp_valid;
  logic [15:0]       rsp_rdata;
  logic              rsp_error;
  logic [4:0]        mdio_phy_addr, mdio_reg_addr;
  logic [15:0]       mdio_wdata;
  logic [1:0]        mdio_op;
  logic              mdio_start, mdio_ready, mdio_error;
  logic [15:0]       mdio_rdata;
  logic              link_up, link_change;

  int errors = 0;
  int checks = 0;

  logic        busy;
  int          cnt;
  logic [15:0] m_rdata, model_rdata = '0;
  logic        m_error, model_error = 1'b0;
  int          starts = 0, overlaps = 0, rsp_count = 0, lc_count = 0, rdy1_count = 0;

  always #5 clk = ~clk;

  mdio_arbiter #(.NREQ(NREQ), .POLL_PHY(5'd0), .POLL_REG(5'd1), .POLL_PERIOD(64)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_phy_addr(req_phy_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .mdio_phy_addr(mdio_phy_addr), .mdio_reg_addr(mdio_reg_addr), .mdio_wdata(mdio_wdata),
    .mdio_op(mdio_op), .mdio_start(mdio_start), .mdio_ready(mdio_ready),
    .mdio_rdata(mdio_rdata), .mdio_error(mdio_error), .link_up(link_up), .link_change(link_change)
  );

  // Behavioural mdio_ctrl: busy for FRAME cycles after a start, result returned when ready rises.
  assign mdio_ready = !busy;
  assign mdio_rdata = m_rdata;
  assign mdio_error = m_error;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0; cnt <= 0; m_rdata <= '0; m_error <= 1'b0;
    end else if (mdio_start) begin
      busy <= 1'b1; cnt <= FRAME;
    end else if (busy) begin
      if (cnt == 1) begin
        busy <= 1'b0; m_rdata <= model_rdata; m_error <= model_error;
      end
      cnt <= cnt - 1;
    end
  end

  always @(posedge clk) begin
    if (mdio_start) starts <= starts + 1;
    if (mdio_start && busy) overlaps <= overlaps + 1;
    if (|rsp_valid) rsp_count <= rsp_count + 1;
    if (link_change) lc_count <= lc_count + 1;
    if (req_ready[1]) rdy1_count <= rdy1_count + 1;
  end

  task automatic set_req(input int i, input logic [1:0] op, input logic [4:0] phy,
                         input logic [4:0] rg, input logic [15:0] wd);
    req_op[2*i +: 2]        = op;
    req_phy_addr[5*i +: 5]  = phy;
    req_reg_addr[5*i +: 5]  = rg;
    req_wdata[16*i +: 16]   = wd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_req(0, 2'b10, 5'd1, 5'd1, 16'h0);
    req_valid = 2'b01;
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
    checks++; if (mdio_start !== 1'b0) begin errors++; $display("FAIL reset_mdio_start: got %b expected 0", mdio_start); end
    checks++; if ({mdio_op, mdio_phy_addr, mdio_reg_addr, mdio_wdata} !== 28'h0) begin errors++;
      $display("FAIL reset_mdio_regs: got %h expected 0", {mdio_op, mdio_phy_addr, mdio_reg_addr, mdio_wdata}); end
    checks++; if ({link_up, link_change, rsp_error} !== 3'b000) begin errors++;
      $display("FAIL reset_link: got %b expected 000", {link_up, link_change, rsp_error}); end
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    int n, lat, s0;
    s0 = starts;
    model_rdata = 16'h796D; model_error = 1'b0;
    set_req(0, 2'b10, 5'd1, 5'd2, 16'h0);
    req_valid = 2'b01;
    n = 0;
    while (req_ready !== 2'b01 && n < 20) begin @(negedge clk); n++; end
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL read_grant: got %b expected 01", req_ready); end
    req_valid = '0;
    checks++; if ({mdio_op, mdio_phy_addr, mdio_reg_addr} !== {2'b10, 5'd1, 5'd2}) begin errors++;
      $display("FAIL read_mdio_fields: got %b/%0d/%0d expected 10/1/2", mdio_op, mdio_phy_addr, mdio_reg_addr); end
    lat = 0;
    while (rsp_valid === 2'b00 && lat < 100) begin @(negedge clk); lat++; end
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL read_rsp_valid: got %b expected 01", rsp_valid); end
    checks++; if (rsp_rdata !== 16'h796D || rsp_error !== 1'b0) begin errors++;
      $display("FAIL read_rsp_data: got %h err %b expected 796d err 0", rsp_rdata, rsp_error); end
    checks++; if (lat != FRAME + 2) begin errors++; $display("FAIL read_latency: got %0d expected %0d", lat, FRAME + 2); end
    @(negedge clk);
    checks++; if (starts - s0 != 1) begin errors++; $display("FAIL read_starts: got %0d expected 1", starts - s0); end
  endtask

  task automatic test_round_robin();
    int n, s0;
    logic [1:0] exp_g;
    s0 = starts;
    set_req(0, 2'b10, 5'd4, 5'd5, 16'h0);
    set_req(1, 2'b10, 5'd6, 5'd7, 16'h0);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
      n = 0;
      while (req_ready === 2'b00 && n < 30) begin @(negedge clk); n++; end
      checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL rr_grant_%0d: got %b expected %b", k, req_ready, exp_g); end
      model_rdata = 16'hA000 + 16'(k);
      n = 0;
      while (rsp_valid === 2'b00 && n < 100) begin @(negedge clk); n++; end
      checks++; if (rsp_valid !== exp_g || rsp_rdata !== 16'hA000 + 16'(k)) begin errors++;
        $display("FAIL rr_rsp_%0d: got %b/%h expected %b/%h", k, rsp_valid, rsp_rdata, exp_g, 16'hA000 + 16'(k)); end
    end
    req_valid = '0;
    repeat (3) @(negedge clk);
    checks++; if (overlaps != 0 || starts - s0 != 4) begin errors++;
      $display("FAIL rr_starts: got overlaps %0d starts %0d expected 0 and 4", overlaps, starts - s0); end
  endtask

  task automatic test_write_error();
    int n;
    model_rdata = 16'hBEEF; model_error = 1'b1;
    set_req(1, 2'b01, 5'd3, 5'd4, 16'h1200);
    req_valid = 2'b10;
    n = 0;
    while (req_ready === 2'b00 && n < 20) begin @(negedge clk); n++; end
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL wr_grant: got %b expected 10", req_ready); end
    req_valid = '0;
    checks++; if ({mdio_op, mdio_reg_addr, mdio_wdata} !== {2'b01, 5'd4, 16'h1200}) begin errors++;
      $display("FAIL wr_mdio_fields: got %b/%0d/%h expected 01/4/1200", mdio_op, mdio_reg_addr, mdio_wdata); end
    n = 0;
    while (rsp_valid === 2'b00 && n < 100) begin @(negedge clk); n++; end
    checks++; if (rsp_valid !== 2'b10 || rsp_error !== 1'b0 || rsp_rdata !== 16'hBEEF) begin errors++;
      $display("FAIL wr_rsp: got %b err %b data %h expected 10 err 0 data beef", rsp_valid, rsp_error, rsp_rdata); end
    model_error = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_illegal_op();
    int n, s0;
    s0 = starts;
    set_req(0, 2'b11, 5'd1, 5'd1, 16'h0);
    req_valid = 2'b01;
    n = 0;
    while (req_ready === 2'b00 && n < 20) begin @(negedge clk); n++; end
    checks++; if (req_ready !== 2'b01 || rsp_valid !== 2'b00) begin errors++;
      $display("FAIL ill_grant: got ready %b rsp %b expected 01/00", req_ready, rsp_valid); end
    req_valid = '0;
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b01 || rsp_error !== 1'b1 || rsp_rdata !== 16'h0) begin errors++;
      $display("FAIL ill_rsp: got %b err %b data %h expected 01 err 1 data 0000", rsp_valid, rsp_error, rsp_rdata); end
    repeat (3) @(negedge clk);
    checks++; if (starts != s0) begin errors++; $display("FAIL ill_no_start: got %0d starts expected 0", starts - s0); end
  endtask

  task automatic test_drop_before_grant();
    int n, s0, r0;
    s0 = starts; r0 = rdy1_count;
    set_req(0, 2'b10, 5'd2, 5'd3, 16'h0);
    set_req(1, 2'b10, 5'd8, 5'd9, 16'h0);
    req_valid = 2'b01;
    n = 0;
    while (req_ready === 2'b00 && n < 20) begin @(negedge clk); n++; end
    req_valid = 2'b10;
    repeat (2) @(negedge clk);
    req_valid = '0;
    n = 0;
    while (rsp_valid === 2'b00 && n < 100) begin @(negedge clk); n++; end
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL drop_rsp: got %b expected 01", rsp_valid); end
    repeat (10) @(negedge clk);
    checks++; if (starts - s0 != 1 || rdy1_count != r0) begin errors++;
      $display("FAIL drop_no_effect: got starts %0d ready1 %0d expected 1 and 0", starts - s0, rdy1_count - r0); end
  endtask

  task automatic test_reset_mid_frame();
    int n, r0, s0;
    set_req(0, 2'b10, 5'd7, 5'd9, 16'h0);
    req_valid = 2'b01;
    n = 0;
    while (req_ready === 2'b00 && n < 20) begin @(negedge clk); n++; end
    req_valid = '0;
    repeat (3) @(negedge clk);
    checks++; if (mdio_phy_addr !== 5'd7 || mdio_ready !== 1'b0) begin errors++;
      $display("FAIL midrst_setup: got phy %0d ready %b expected 7 and 0", mdio_phy_addr, mdio_ready); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({req_ready, rsp_valid, mdio_start, mdio_op, mdio_phy_addr, mdio_reg_addr, rsp_rdata, rsp_error} !== 39'h0) begin errors++;
      $display("FAIL midrst_outputs: got %h expected 0", {req_ready, rsp_valid, mdio_start, mdio_op, mdio_phy_addr, mdio_reg_addr, rsp_rdata, rsp_error}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    r0 = rsp_count; s0 = starts;
    repeat (20) @(negedge clk);
    checks++; if (rsp_count != r0 || starts != s0) begin errors++;
      $display("FAIL midrst_silent: got rsp %0d starts %0d expected 0 and 0", rsp_count - r0, starts - s0); end
  endtask

  task automatic test_no_poll();
    int s0;
    s0 = starts;
    repeat (200) @(negedge clk);
    checks++; if (starts != s0 || link_up !== 1'b0 || lc_count != 0) begin errors++;
      $display("FAIL no_poll: got starts %0d link %b changes %0d expected 0/0/0", starts - s0, link_up, lc_count); end
  endtask

  task automatic test_poll();
    int n, lc0, r0, s0;
    lc0 = lc_count; r0 = rsp_count;
    model_rdata = 16'h0004; model_error = 1'b0;
    n = 0;
    while (link_change !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++; if (link_change !== 1'b1 || link_up !== 1'b1) begin errors++;
      $display("FAIL poll_up: got change %b link %b expected 1/1", link_change, link_up); end
    checks++; if (mdio_phy_addr !== 5'd0 || mdio_reg_addr !== 5'd1 || mdio_op !== 2'b10) begin errors++;
      $display("FAIL poll_frame: got %0d/%0d/%b expected 0/1/10", mdio_phy_addr, mdio_reg_addr, mdio_op); end
    model_rdata = 16'h0000; model_error = 1'b1;
    s0 = starts;
    n = 0;
    while (starts == s0 && n < 200) begin @(negedge clk); n++; end
    repeat (12) @(negedge clk);
    checks++; if (link_up !== 1'b1 || lc_count != lc0 + 1 || starts == s0) begin errors++;
      $display("FAIL poll_err_hold: got link %b changes %0d expected 1 and 1", link_up, lc_count - lc0); end
    model_error = 1'b0;
    n = 0;
    while (link_change !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++; if (link_change !== 1'b1 || link_up !== 1'b0) begin errors++;
      $display("FAIL poll_down: got change %b link %b expected 1/0", link_change, link_up); end
    @(negedge clk);
    checks++; if (lc_count != lc0 + 2 || rsp_count != r0) begin errors++;
      $display("FAIL poll_counts: got changes %0d rsp %0d expected 2 and 0", lc_count - lc0, rsp_count - r0); end
  endtask

  initial begin
    test_reset();
`ifdef MDIO_POLL_EN
    test_poll();
`else
    test_single_read();
    test_round_robin();
    test_write_error();
    test_illegal_op();
    test_drop_before_grant();
    test_reset_mid_frame();
    test_no_poll();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
